ex_alu_wbck_buf: RTL

EX_ALU_WBCK_BUF -- requirements
Module: ex_alu_wbck_buf

---
 rtl/ex_alu_wbck_buf.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ex_alu_wbck_buf.sv
// Buffers ALU results and arbitrates register-file writeback against the long pipe, with anti-starvation forcing.
// Latency: 1 cycle minimum from alui accept to commit (no bypass).
// Backpressure: alui_ready drops when the FIFO is full; longp_ready drops only while the ALU is forced to win.
module ex_alu_wbck_buf #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 7,
    parameter int E203_XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 alui_valid,
    output logic                 alui_ready,
    input  logic [E203_XLEN-1:0] alui_wdat,
    input  logic [4:0]           alui_rdidx,
    input  logic                 alui_rdwen,
    input  logic                 alui_err,
    input  logic                 alui_ecall,
    input  logic                 alui_ebreak,
    input  logic                 alui_wfi,

    input  logic                 longp_valid,
    output logic                 longp_ready,
    input  logic [E203_XLEN-1:0] longp_wdat,
    input  logic [4:0]           longp_rdidx,
    input  logic                 longp_rdwen,

    output logic                 cmt_valid,
    input  logic                 cmt_ready,
    output logic                 cmt_err,
    output logic                 cmt_ecall,
    output logic                 cmt_ebreak,
    output logic                 cmt_wfi,

    output logic                 rf_wbck_ena,
    output logic [4:0]           rf_wbck_idx,
    output logic [E203_XLEN-1:0] rf_wbck_dat
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [E203_XLEN-1:0] wdat;
        logic [4:0]           rdidx;
        logic                 rdwen;
        logic                 err;
        logic                 ecall;
        logic                 ebreak;
        logic                 wfi;
    } entry_t;

    entry_t         mem [FIFO_DEPTH];
    entry_t         entry_in;
    entry_t         head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [SW-1:0]  starve_cnt;
    logic           force_alu;
    logic           head_vld;
    logic           push;
    logic           pop;
    logic           long_wr;

    assign entry_in = '{wdat:   alui_wdat,
                        rdidx:  alui_rdidx,
                        rdwen:  alui_rdwen,
                        err:    alui_err,
                        ecall:  alui_ecall,
                        ebreak: alui_ebreak,
                        wfi:    alui_wfi};

    assign head      = mem[rd_ptr];
    assign head_vld  = (count != '0);
    assign force_alu = (starve_cnt == SW'(STARVE_MAX));

    // Full blocks a push even when the head leaves in the same cycle.
    assign alui_ready = (count != CW'(FIFO_DEPTH));
    assign push       = alui_valid & alui_ready;

    assign longp_ready = ~force_alu;
    assign long_wr     = longp_valid & longp_ready;
    assign cmt_valid   = head_vld & (~longp_valid | force_alu);
    assign pop         = cmt_valid & cmt_ready;

    assign cmt_err    = head_vld & head.err;
    assign cmt_ecall  = head_vld & head.ecall;
    assign cmt_ebreak = head_vld & head.ebreak;
    assign cmt_wfi    = head_vld & head.wfi;

    // Faulting entries still commit but never touch the register file.
    assign rf_wbck_ena = rst_n & ((long_wr & longp_rdwen) | (pop & head.rdwen & ~head.err));
    assign rf_wbck_idx = long_wr ? longp_rdidx : head.rdidx;
    assign rf_wbck_dat = long_wr ? longp_wdat  : head.wdat;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Saturates at STARVE_MAX, which holds force until the head pops.
            if (pop || !head_vld) begin
                starve_cnt <= '0;
            end else if (longp_valid && !force_alu) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule
